// File: rtl/apb_reg_slave.sv
// apb_reg_slave
// APB3/APB4 completer holding a bank of 32-bit registers. Register 0 is a
// read-only ID word. Writes honour byte strobes, and every transfer is
// stretched by a fixed number of wait states. Unaligned addresses,
// out-of-window addresses and writes to the ID register complete with PSLVERR.
//
// Ports:
//   PCLK     clock, all state changes on the rising edge
//   PRESET   asynchronous active-high reset
//   PADDR    byte address (ADDR_W bits)
//   PSEL     completer select
//   PENABLE  access-phase indicator
//   PWRITE   1 = write, 0 = read
//   PWDATA   write data, sampled on the completing edge
//   PWSTRB   byte lane strobes, bit n qualifies PWDATA[8n+7:8n]
//   PREADY   transfer completion (combinational)
//   PRDATA   read data, non-zero only on a completing read
//   PSLVERR  error response, only while PREADY is high
module apb_reg_slave #(
    parameter int                ADDR_W      = 32,
    parameter int                NUM_REGS    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_STATES = 1,
    parameter logic [31:0]       ID_VALUE    = 32'hA5A5_0001
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PWDATA,
    input  logic [3:0]        PWSTRB,
    output logic              PREADY,
    output logic [31:0]       PRDATA,
    output logic              PSLVERR
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t            state, state_next;
    logic [3:0]        cnt, cnt_next;
    logic              take_setup;

    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] idx_full;
    logic              hit, aligned, err;

    logic [IDX_W-1:0]  lat_idx;
    logic              lat_write;
    logic              lat_err;

    logic              commit;

    // Register 0 is the constant ID word, so only 1..NUM_REGS-1 need storage.
    logic [31:0]       regs [1:NUM_REGS-1];

    // Address decode of the live bus. Because BASE_ADDR is word aligned,
    // the low two bits of the offset are the alignment bits of PADDR.
    always_comb begin
        off      = PADDR - BASE_ADDR;
        idx_full = off >> 2;
        hit      = (PADDR >= BASE_ADDR) && (idx_full < ADDR_W'(NUM_REGS));
        aligned  = (off[1:0] == 2'b00);
        err      = !hit || !aligned || (PWRITE && (idx_full == '0));
    end

    // Completion is combinational so that the ready cycle count equals
    // WAIT_STATES + 1 access cycles.
    assign PREADY  = (state == ACCESS) && PSEL && PENABLE && (cnt == 4'(WAIT_STATES));
    assign PSLVERR = PREADY && lat_err;
    assign commit  = PREADY && lat_write && !lat_err;

    // Read data is forced to zero outside a completing, error-free read.
    always_comb begin
        PRDATA = '0;
        if (PREADY && !lat_write && !lat_err) begin
            if (lat_idx == '0) begin
                PRDATA = ID_VALUE;
            end else begin
                PRDATA = regs[lat_idx];
            end
        end
    end

    // Next-state logic. A PSEL+PENABLE pair seen in IDLE is a protocol
    // violation and is simply ignored. Dropping PSEL in ACCESS aborts.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        take_setup = 1'b0;
        case (state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_next = ACCESS;
                    cnt_next   = '0;
                    take_setup = 1'b1;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_next = IDLE;
                end else if (PREADY) begin
                    state_next = IDLE;
                end else if (PENABLE) begin
                    cnt_next = cnt + 4'd1;
                end
            end
        endcase
    end

    // State, wait counter and the setup-phase snapshot of address/control.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_idx   <= '0;
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (take_setup) begin
                lat_idx   <= idx_full[IDX_W-1:0];
                lat_write <= PWRITE;
                lat_err   <= err;
            end
        end
    end

    // Register bank. Write data and strobes are taken from the bus on the
    // completing edge; lat_idx is never 0 here because that is an error.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            for (int n = 0; n < 4; n++) begin
                if (PWSTRB[n]) begin
                    regs[lat_idx][8*n +: 8] <= PWDATA[8*n +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// tb_apb_reg_slave
// Self-checking bench for apb_reg_slave. The main instance uses one wait
// state. Two extra instances with zero and three wait states share the bus
// and are only observed during the wait-state sweep. Expected values come
// from a word-array model of the register window.
module tb_apb_reg_slave;

    localparam int          NUM_REGS = 32;
    localparam logic [31:0] BASE     = 32'h0;
    localparam logic [31:0] ID       = 32'hA5A5_0001;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PWSTRB;

    logic        ready0, ready1, ready3;
    logic [31:0] rdata0, rdata1, rdata3;
    logic        slverr0, slverr1, slverr3;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [0:NUM_REGS-1];

    always #5 PCLK = ~PCLK;

    apb_reg_slave #(.ADDR_W(32), .NUM_REGS(NUM_REGS), .BASE_ADDR(BASE),
                    .WAIT_STATES(1), .ID_VALUE(ID)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PWSTRB(PWSTRB),
        .PREADY(ready1), .PRDATA(rdata1), .PSLVERR(slverr1)
    );

    apb_reg_slave #(.ADDR_W(32), .NUM_REGS(NUM_REGS), .BASE_ADDR(BASE),
                    .WAIT_STATES(0), .ID_VALUE(ID)) dut_ws0 (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PWSTRB(PWSTRB),
        .PREADY(ready0), .PRDATA(rdata0), .PSLVERR(slverr0)
    );

    apb_reg_slave #(.ADDR_W(32), .NUM_REGS(NUM_REGS), .BASE_ADDR(BASE),
                    .WAIT_STATES(3), .ID_VALUE(ID)) dut_ws3 (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PWSTRB(PWSTRB),
        .PREADY(ready3), .PRDATA(rdata3), .PSLVERR(slverr3)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic expErr(input logic wr, input logic [31:0] a);
        logic [31:0] idx;
        if (a < BASE) return 1'b1;
        if ((a % 32'd4) != 32'd0) return 1'b1;
        idx = (a - BASE) / 32'd4;
        if (idx >= 32'(NUM_REGS)) return 1'b1;
        return wr && (idx == 32'd0);
    endfunction

    function automatic logic [31:0] expRead(input logic [31:0] a);
        if (expErr(1'b0, a)) return 32'h0;
        return model[(a - BASE) / 32'd4];
    endfunction

    task automatic modelReset();
        model[0] = ID;
        for (int i = 1; i < NUM_REGS; i++) model[i] = 32'h0;
    endtask

    // One full transfer on the main instance, entered and left just after a
    // rising edge so that consecutive calls run back to back. PADDR is
    // scrambled during the access phase, which the DUT must ignore.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, output logic [31:0] rd, output logic er,
                                 output int cyc, output logic done);
        done = 1'b0; rd = '0; er = 1'b0; cyc = 0;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data; PWSTRB = strb;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        PADDR   = $urandom();
        for (int i = 1; i <= 20 && !done; i++) begin
            @(negedge PCLK);
            if (ready1) begin
                done = 1'b1; cyc = i; rd = rdata1; er = slverr1;
            end
            @(posedge PCLK); #1;
        end
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb, output logic [31:0] rd);
        logic        er, done, e_err;
        logic [31:0] e_rd, idx;
        int          cyc;
        e_err = expErr(wr, addr);
        e_rd  = wr ? 32'h0 : expRead(addr);
        applyStimulus(wr, addr, data, strb, rd, er, cyc, done);
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        if (done) begin
            checkOutput({tag, "_latency"}, 32'(cyc), 32'd2);
            checkOutput({tag, "_slverr"}, 32'(er), 32'(e_err));
            checkOutput({tag, "_prdata"}, rd, e_rd);
        end
        if (wr && !e_err) begin
            idx = (addr - BASE) / 32'd4;
            for (int n = 0; n < 4; n++)
                if (strb[n]) model[idx][8*n +: 8] = data[8*n +: 8];
        end
    endtask

    task automatic idle(input int n);
        PSEL = 1'b0; PENABLE = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge PCLK); #1;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] d0, d3, a;
        int          f0, f1, f3;
        logic        wr;

        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PWSTRB = '0;
        modelReset();
        @(negedge PCLK);
        checkOutput("reset_pready", 32'(ready1), 32'd0);
        checkOutput("reset_prdata", rdata1, 32'd0);
        checkOutput("reset_pslverr", 32'(slverr1), 32'd0);
        @(negedge PCLK);
        PRESET = 1'b0;
        @(posedge PCLK); #1;

        $display("[TB] directed transfers");
        xfer("wr48", 1'b1, 32'd48, 32'd56, 4'hF, rd);
        xfer("rd48", 1'b0, 32'd48, 32'h0, 4'h0, rd);
        checkOutput("rd48_value", rd, 32'd56);
        xfer("wr49_unaligned", 1'b1, 32'd49, 32'd78, 4'hF, rd);
        xfer("rd48_again", 1'b0, 32'd48, 32'h0, 4'h0, rd);
        checkOutput("rd48_again_value", rd, 32'd56);
        xfer("wr76_full", 1'b1, 32'd76, 32'h1122_3344, 4'hF, rd);
        xfer("wr76_strb", 1'b1, 32'd76, 32'hFFFF_FFFF, 4'b0101, rd);
        xfer("rd76", 1'b0, 32'd76, 32'h0, 4'h0, rd);
        checkOutput("rd76_value", rd, 32'h11FF_33FF);
        xfer("rd_id", 1'b0, 32'd0, 32'h0, 4'h0, rd);
        checkOutput("rd_id_value", rd, ID);
        xfer("wr_id", 1'b1, 32'd0, 32'h1234_5678, 4'hF, rd);
        xfer("rd_id_again", 1'b0, 32'd0, 32'h0, 4'h0, rd);
        checkOutput("rd_id_again_value", rd, ID);
        xfer("rd128_oow", 1'b0, 32'd128, 32'h0, 4'h0, rd);
        xfer("wr52_nostrb", 1'b1, 32'd52, 32'hCAFE_F00D, 4'h0, rd);
        xfer("rd52", 1'b0, 32'd52, 32'h0, 4'h0, rd);
        checkOutput("rd52_value", rd, 32'h0);
        idle(2);

        $display("[TB] abort in access phase");
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'd80;
        PWDATA = 32'hDEAD_BEEF; PWSTRB = 4'hF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        checkOutput("abort_noready", 32'(ready1), 32'd0);
        @(posedge PCLK); #1;
        idle(2);
        xfer("rd80_after_abort", 1'b0, 32'd80, 32'h0, 4'h0, rd);
        checkOutput("rd80_value", rd, 32'h0);
        idle(2);

        $display("[TB] wait-state sweep");
        f0 = 0; f1 = 0; f3 = 0; d0 = '0; d3 = '0;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'd0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge PCLK);
            if (ready0 && f0 == 0) begin f0 = i; d0 = rdata0; end
            if (ready1 && f1 == 0) f1 = i;
            if (ready3 && f3 == 0) begin f3 = i; d3 = rdata3; end
            @(posedge PCLK); #1;
        end
        idle(2);
        checkOutput("ws0_first_ready", 32'(f0), 32'd1);
        checkOutput("ws1_first_ready", 32'(f1), 32'd2);
        checkOutput("ws3_first_ready", 32'(f3), 32'd4);
        checkOutput("ws0_id", d0, ID);
        checkOutput("ws3_id", d3, ID);

        $display("[TB] reset during access");
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'd48;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        @(negedge PCLK);
        checkOutput("pre_reset_ready", 32'(ready1), 32'd1);
        checkOutput("pre_reset_rdata", rdata1, 32'd56);
        #1 PRESET = 1'b1;
        #1;
        checkOutput("midreset_pready", 32'(ready1), 32'd0);
        checkOutput("midreset_prdata", rdata1, 32'd0);
        checkOutput("midreset_pslverr", 32'(slverr1), 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
        modelReset();
        @(posedge PCLK); #1;
        @(negedge PCLK);
        PRESET = 1'b0;
        @(posedge PCLK); #1;
        xfer("rd48_after_reset", 1'b0, 32'd48, 32'h0, 4'h0, rd);
        checkOutput("rd48_after_reset_value", rd, 32'h0);

        $display("[TB] randomized transfers");
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 4))
                0, 1:    a = 32'($urandom_range(1, NUM_REGS - 1)) * 32'd4;
                2:       a = 32'($urandom_range(1, NUM_REGS - 1)) * 32'd4 + 32'($urandom_range(1, 3));
                3:       a = 32'($urandom_range(NUM_REGS, NUM_REGS + 40)) * 32'd4;
                default: a = 32'd0;
            endcase
            wr = 1'($urandom_range(0, 1));
            xfer("rand", wr, BASE + a, $urandom(), 4'($urandom_range(0, 15)), rd);
            if ($urandom_range(0, 2) == 0) idle(1);
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
